// File: rtl/regfile_seq.sv
// Four-phase instruction sequencer driving an external register file:
// IDLE accepts, READ addresses the file, EXEC computes, WB writes back.
module regfile_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [15:0]   INSTR,
  input  logic          VALID,
  output logic          READY,
  input  logic          ERR_CLR,
  input  logic [DW-1:0] DataA,
  input  logic [DW-1:0] DataB,
  output logic [AW-1:0] SA,
  output logic [AW-1:0] SB,
  output logic [AW-1:0] DR,
  output logic          LD,
  output logic [DW-1:0] D_in,
  output logic          DONE,
  output logic          Z,
  output logic          C,
  output logic          ERR
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned IMMW = 8;

  localparam logic [OPW-1:0] OP_NOP = 4'd0;
  localparam logic [OPW-1:0] OP_MOV = 4'd1;
  localparam logic [OPW-1:0] OP_ADD = 4'd2;
  localparam logic [OPW-1:0] OP_SUB = 4'd3;
  localparam logic [OPW-1:0] OP_AND = 4'd4;
  localparam logic [OPW-1:0] OP_OR  = 4'd5;
  localparam logic [OPW-1:0] OP_XOR = 4'd6;
  localparam logic [OPW-1:0] OP_LDI = 4'd7;
  localparam logic [OPW-1:0] OP_SHR = 4'd8;
  localparam logic [OPW-1:0] OP_SHL = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t          state;
  logic [OPW-1:0]  op_q;
  logic [IMMW-1:0] imm_q;

  logic [DW:0]     alu_wide_c;
  logic [DW-1:0]   alu_res_c;
  logic            alu_carry_c;
  logic            alu_wr_c;
  logic            alu_illegal_c;

  // ALU: combinational on the latched opcode and the register-file read data
  always_comb begin
    alu_wide_c    = '0;
    alu_res_c     = '0;
    alu_carry_c   = 1'b0;
    alu_wr_c      = 1'b1;
    alu_illegal_c = 1'b0;
    unique case (op_q)
      OP_MOV: alu_res_c = DataA;
      OP_ADD: begin
        alu_wide_c  = {1'b0, DataA} + {1'b0, DataB};
        alu_res_c   = alu_wide_c[DW-1:0];
        alu_carry_c = alu_wide_c[DW];
      end
      OP_SUB: begin
        // the extra top bit of a DW+1 subtraction is the borrow (A < B)
        alu_wide_c  = {1'b0, DataA} - {1'b0, DataB};
        alu_res_c   = alu_wide_c[DW-1:0];
        alu_carry_c = alu_wide_c[DW];
      end
      OP_AND: alu_res_c = DataA & DataB;
      OP_OR:  alu_res_c = DataA | DataB;
      OP_XOR: alu_res_c = DataA ^ DataB;
      OP_LDI: alu_res_c = DW'(imm_q);
      OP_SHR: begin
        alu_res_c   = DataA >> 1;
        alu_carry_c = DataA[0];
      end
      OP_SHL: begin
        alu_res_c   = DataA << 1;
        alu_carry_c = DataA[DW-1];
      end
      OP_NOP: alu_wr_c = 1'b0;
      default: begin
        alu_wr_c      = 1'b0;
        alu_illegal_c = 1'b1;
      end
    endcase
  end

  // Sequencer with all outputs registered
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      op_q  <= '0;
      imm_q <= '0;
      READY <= 1'b1;
      SA    <= '0;
      SB    <= '0;
      DR    <= '0;
      LD    <= 1'b0;
      D_in  <= '0;
      DONE  <= 1'b0;
      Z     <= 1'b0;
      C     <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      LD   <= 1'b0;
      DONE <= 1'b0;
      if (ERR_CLR) begin
        ERR <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (VALID && READY) begin
            op_q  <= INSTR[15:12];
            imm_q <= INSTR[7:0];
            DR    <= AW'(INSTR[11:9]);
            SA    <= AW'(INSTR[8:6]);
            SB    <= AW'(INSTR[5:3]);
            READY <= 1'b0;
            state <= READ;
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          DONE  <= 1'b1;
          state <= WB;
          if (alu_wr_c) begin
            LD   <= 1'b1;
            D_in <= alu_res_c;
            Z    <= (alu_res_c == '0);
            C    <= alu_carry_c;
          end
          // placed after the clear so a coincident set wins
          if (alu_illegal_c) begin
            ERR <= 1'b1;
          end
        end
        WB: begin
          READY <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Randomised scoreboard bench for regfile_seq with an arithmetic reference
// model and an external register file.
module tb_regfile_seq;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;
  localparam int          MODV = 256;

  logic          CLK;
  logic          RESET_N;
  logic [15:0]   INSTR;
  logic          VALID;
  logic          READY;
  logic          ERR_CLR;
  logic [DW-1:0] DataA;
  logic [DW-1:0] DataB;
  logic [AW-1:0] SA;
  logic [AW-1:0] SB;
  logic [AW-1:0] DR;
  logic          LD;
  logic [DW-1:0] D_in;
  logic          DONE;
  logic          Z;
  logic          C;
  logic          ERR;

  regfile_seq #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INSTR(INSTR), .VALID(VALID), .READY(READY),
    .ERR_CLR(ERR_CLR), .DataA(DataA), .DataB(DataB), .SA(SA), .SB(SB), .DR(DR),
    .LD(LD), .D_in(D_in), .DONE(DONE), .Z(Z), .C(C), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External register file
  logic [DW-1:0] regs [NREG];
  assign DataA = regs[SA];
  assign DataB = regs[SB];
  always @(posedge CLK) if (LD === 1'b1) regs[DR] <= D_in;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int acc;
    bit ld;
    int dr;
    int d;
    bit z;
    bit c;
    bit err;
  } exp_t;

  exp_t q[$];
  exp_t me;

  int mregs [NREG];
  int mlast;
  bit mz, mc, merr;
  int s_regs [NREG];
  int s_last;
  bit s_z, s_c, s_err;

  int checks = 0;
  int errors = 0;
  bit acc_f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
    return {4'd7, d, 1'b0, imm};
  endfunction

  // Reference model: compute the expected retirement of an accepted instruction
  task automatic push(input logic [15:0] ins);
    int op, d, sa, sb, imm, a, b, r;
    bit c, wr;
    exp_t e;
    op = int'(ins[15:12]); d = int'(ins[11:9]); sa = int'(ins[8:6]);
    sb = int'(ins[5:3]); imm = int'(ins[7:0]);
    foreach (mregs[i]) s_regs[i] = mregs[i];
    s_last = mlast; s_z = mz; s_c = mc; s_err = merr;
    a = mregs[sa]; b = mregs[sb];
    r = 0; c = 1'b0; wr = 1'b1;
    case (op)
      1: r = a;
      2: begin r = (a + b) % MODV; c = (a + b) >= MODV; end
      3: begin r = (a - b + MODV) % MODV; c = a < b; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = imm;
      8: begin r = a / 2; c = (a % 2) == 1; end
      9: begin r = (a * 2) % MODV; c = a >= MODV / 2; end
      default: wr = 1'b0;
    endcase
    if (op >= 10) merr = 1'b1;
    if (wr) begin
      mregs[d] = r; mlast = r; mz = (r == 0); mc = c;
    end
    e.acc = cyc; e.ld = wr; e.dr = d; e.d = mlast; e.z = mz; e.c = mc; e.err = merr;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation each time the DUT retires an instruction
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (LD === 1'b1 && DONE !== 1'b1) check("ld_outside_wb", 32'(LD), 0);
      if (DONE === 1'b1) begin
        if (q.size() == 0) begin
          check("done_unexpected", 32'(DONE), 0);
        end else begin
          me = q.pop_front();
          check("done_latency", cyc - me.acc, 3);
          check("ld", 32'(LD), 32'(me.ld));
          if (me.ld) check("dr", 32'(DR), me.dr);
          check("d_in", 32'(D_in), me.d);
          check("z", 32'(Z), 32'(me.z));
          check("c", 32'(C), 32'(me.c));
          check("err", 32'(ERR), 32'(me.err));
        end
      end
    end
  end

  task automatic drive_cycle(input bit v, input logic [15:0] ins, input bit clr);
    @(negedge CLK);
    VALID = v; INSTR = ins; ERR_CLR = clr;
    acc_f = v && (READY === 1'b1);
    if (acc_f) push(ins);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic issue(input logic [15:0] ins);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, ins, 1'b0);
      if (acc_f) break;
    end
    if (!acc_f) check("accept_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(READY), 1);
    check({tag, "_ld"}, 32'(LD), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_zce"}, 32'({Z, C, ERR}), 0);
    check({tag, "_addr"}, 32'({SA, SB, DR}), 0);
    check({tag, "_d_in"}, 32'(D_in), 0);
  endtask

  int n_acc;

  initial begin
    foreach (regs[i]) regs[i] = '0;
    foreach (mregs[i]) mregs[i] = 0;
    mlast = 0; mz = 0; mc = 0; merr = 0;
    VALID = 0; INSTR = '0; ERR_CLR = 0; RESET_N = 0;
    repeat (2) @(negedge CLK);
    check_reset_vals("por");
    RESET_N = 1;

    // Dependent LDI/LDI/ADD chain
    issue(ldi(3'd1, 8'h05));
    issue(ldi(3'd2, 8'h03));
    issue(mk(4'd2, 3'd3, 3'd1, 3'd2));
    idle(4);
    check("r3_sum", 32'(regs[3]), 32'h08);

    // Carry and borrow boundaries
    issue(ldi(3'd1, 8'hFF));
    issue(ldi(3'd2, 8'h01));
    issue(mk(4'd2, 3'd4, 3'd1, 3'd2));
    issue(mk(4'd3, 3'd5, 3'd2, 3'd1));
    idle(4);
    check("r4_wrap", 32'(regs[4]), 32'h00);
    check("r5_borrow", 32'(regs[5]), 32'h02);

    // Illegal opcode, sticky error and clear
    issue(16'hC000);
    idle(6);
    check("err_held", 32'(ERR), 1);
    drive_cycle(1'b0, 16'h0, 1'b1);
    merr = 1'b0;
    drive_cycle(1'b0, 16'h0, 1'b0);
    check("err_cleared", 32'(ERR), 0);
    // clear coinciding with the set edge: set wins
    issue(16'hD000);
    drive_cycle(1'b0, 16'h0, 1'b0);
    drive_cycle(1'b0, 16'h0, 1'b1);
    drive_cycle(1'b0, 16'h0, 1'b0);
    idle(3);
    check("err_set_wins", 32'(ERR), 1);

    // VALID held high with changing INSTR
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 16'($urandom), 1'b0);
      if (acc_f) n_acc++;
    end
    idle(4);
    check("accepts_per_40", n_acc, 10);

    // Random traffic
    for (int i = 0; i < 300; i++)
      drive_cycle(1'($urandom), 16'($urandom), 1'b0);
    idle(6);

    // Reset during EXEC of an ADD
    issue(mk(4'd2, 3'd6, 3'd1, 3'd2));
    drive_cycle(1'b0, 16'h0, 1'b0);
    @(negedge CLK);
    RESET_N = 0; VALID = 0;
    #1;
    check_reset_vals("mid_rst");
    q.delete();
    foreach (mregs[i]) mregs[i] = s_regs[i];
    mlast = 0; mz = 0; mc = 0; merr = 0;
    repeat (2) begin
      @(negedge CLK);
      check("rst_no_ld", 32'(LD), 0);
    end
    RESET_N = 1;
    @(negedge CLK);
    check("ready_after_rst", 32'(READY), 1);
    check("r6_untouched", 32'(regs[6]), mregs[6]);
    issue(ldi(3'd7, 8'h5A));
    idle(5);
    check("r7_ldi", 32'(regs[7]), 32'h5A);

    idle(4);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
